multi_channel_counter_display: RTL

// - Parametrised successor to the two-display button counters: NUM_CH independent
//   up/down counters, each DIGITS nibbles wide, each HEX or DEC per MODE_HEX.
// - Sits between the per-button debouncers (single-cycle pulses) and the board's

---
 rtl/multi_channel_counter_display_if.sv | 15 +
 rtl/multi_channel_counter_display.sv | 110 +++++++++++
 2 files changed

// File: rtl/multi_channel_counter_display_if.sv
// multi_channel_counter_display_if: button pulses in, counts and 7-segment drive out
interface multi_channel_counter_display_if #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 2
);
    logic [NUM_CH-1:0]          inc;
    logic [NUM_CH-1:0]          dec;
    logic [NUM_CH-1:0]          clr;
    logic [NUM_CH*DIGITS*4-1:0] count;
    logic [NUM_CH-1:0]          ovf;
    logic [NUM_CH*DIGITS-1:0]   anode;
    logic [7:0]                 cathode;
    modport master (output inc, dec, clr, input count, ovf, anode, cathode);
    modport slave  (input inc, dec, clr, output count, ovf, anode, cathode);
endinterface

// File: rtl/multi_channel_counter_display.sv
// multi_channel_counter_display: NUM_CH up/down HEX/DEC counters scanned onto one 7-segment bank
// Build option: define MCD_LEADING_ZERO_BLANK_EN to blank each channel's leading zero digits
module multi_channel_counter_display #(
    parameter int                NUM_CH    = 4,
    parameter int                DIGITS    = 2,
    parameter logic [NUM_CH-1:0] MODE_HEX  = 4'b0101,
    parameter int                CLK_PER   = 10,
    parameter int                REFR_RATE = 1000,
    parameter int                SCAN_CYC  = (1_000_000_000 / CLK_PER) / (REFR_RATE * NUM_CH * DIGITS)
) (
    input logic clk,
    input logic CPU_RESETN,
    multi_channel_counter_display_if.slave bus
);
    localparam int CW    = DIGITS * 4;
    localparam int TOTAL = NUM_CH * DIGITS;
    localparam int TW    = $clog2(SCAN_CYC);
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // One ripple step of a multi-digit count; the extra top bit flags a full wrap
    function automatic logic [CW:0] step(input logic [CW-1:0] v, input logic up, input logic hex);
        logic [3:0] lim;
        logic [3:0] nib;
        logic       rip;
        lim  = hex ? 4'hF : 4'h9;
        rip  = 1'b1;
        step = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[i*4 +: 4];
            step[i*4 +: 4] = !rip ? nib :
                             up   ? ((nib == lim)  ? 4'h0 : nib + 4'h1) :
                                    ((nib == 4'h0) ? lim  : nib - 4'h1);
            rip = rip && (up ? (nib == lim) : (nib == 4'h0));
        end
        step[CW] = rip;
    endfunction

    logic [TOTAL*4-1:0] cnt_all;
    logic [NUM_CH-1:0]  ovf_all;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          ov;
        logic [CW:0]   up_v;
        logic [CW:0]   dn_v;
        assign up_v = step(cnt, 1'b1, MODE_HEX[c]);
        assign dn_v = step(cnt, 1'b0, MODE_HEX[c]);
        // Channel counter: clear wins, inc with dec holds, a wrap latches the sticky overflow
        always_ff @(posedge clk or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                cnt <= '0;
                ov  <= 1'b0;
            end else if (bus.clr[c]) begin
                cnt <= '0;
                ov  <= 1'b0;
            end else if (bus.inc[c] && !bus.dec[c]) begin
                cnt <= up_v[CW-1:0];
                ov  <= ov | up_v[CW];
            end else if (bus.dec[c] && !bus.inc[c]) begin
                cnt <= dn_v[CW-1:0];
                ov  <= ov | dn_v[CW];
            end
        end
        assign cnt_all[c*CW +: CW] = cnt;
        assign ovf_all[c]          = ov;
    end

    // Slot k shows nibble k of the packed counts, so per-slot attributes are static wiring
    logic [TOTAL-1:0] blank;
    logic [TOTAL-1:0] dp;
    for (genvar k = 0; k < TOTAL; k++) begin : g_slot
        assign dp[k] = (k % DIGITS == 0) && ovf_all[k / DIGITS];
`ifdef MCD_LEADING_ZERO_BLANK_EN
        assign blank[k] = (k % DIGITS != 0) && (cnt_all[k*4 +: (DIGITS - k % DIGITS) * 4] == '0);
`else
        assign blank[k] = 1'b0;
`endif
    end

    logic [TW-1:0]    timer;
    logic [IW-1:0]    idx;
    logic [TOTAL-1:0] anode;
    logic [7:0]       cathode;

    // Slot timer and index; the display registers sample the current slot only on terminal count
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            timer   <= '0;
            idx     <= '0;
            anode   <= '1;
            cathode <= 8'hFF;
        end else if (timer == TW'(SCAN_CYC - 1)) begin
            timer   <= '0;
            idx     <= (idx == IW'(TOTAL - 1)) ? '0 : idx + IW'(1);
            anode   <= ~(TOTAL'(1) << idx);
            cathode <= {~dp[idx], blank[idx] ? 7'h7F : GLYPH[cnt_all[idx*4 +: 4]]};
        end else begin
            timer <= timer + TW'(1);
        end
    end

    assign bus.count   = cnt_all;
    assign bus.ovf     = ovf_all;
    assign bus.anode   = anode;
    assign bus.cathode = cathode;
endmodule
